// File: rtl/mmio_seg7_port_pkg.sv
// Shared constants for the memory-mapped seven-segment/LED output port.
package mmio_seg7_port_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] OFF_DISP   = 2'd0;
  localparam logic [1:0] OFF_LED    = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_DP_LSB    = 8;
  localparam int unsigned CTRL_BLANK_LSB = 16;

  localparam logic [DATA_W-1:0] CTRL_RST   = 32'h0000_0001;
  localparam logic [DATA_W-1:0] CTRL_WMASK = 32'h00FF_FF01;
  localparam logic [DATA_W-1:0] LED_WMASK  = 32'h0000_FFFF;

  // Expand per-byte enables into a 32-bit bit mask.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mmio_seg7_port_hex_to_seg7.sv
// Hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (nib_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/mmio_seg7_port.sv
// Store-driven display/LED port on the data-memory bus with load readback
// and a free-running time-multiplexed digit scanner.
module mmio_seg7_port
  import mmio_seg7_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int unsigned SCAN_DIV  = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [15:0] led
);

  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

  logic [31:0]        disp_q, disp_d, ledreg_q, ledreg_d, ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [15:0]        frame_q, frame_d;
  logic [7:0]         seg_q, seg_d, an_q, an_d;
  logic [15:0]        led_q;

  logic [3:0]  be;
  logic [31:0] wdata, wmask, rword, rshift;
  logic        tick, digit_on;
  logic [3:0]  nib;
  logic [6:0]  hex_seg;
  logic [7:0]  dp_mask, blank_mask;

  assign hit = (Addr[31:4] == BASE_ADDR[31:4]);

  // Store lane decode: misaligned or non-store sizes produce no enables.
  always_comb begin
    be    = 4'b0000;
    wdata = WriteData;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << Addr[1:0];
        wdata = {4{WriteData[7:0]}};
      end
      F3_H: begin
        if (!Addr[0]) be = Addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteData[15:0]}};
      end
      F3_W: begin
        if (Addr[1:0] == 2'b00) be = 4'b1111;
      end
      default: be = 4'b0000;
    endcase
    wmask = lane_mask(be);
  end

  always_comb begin
    disp_d   = disp_q;
    ledreg_d = ledreg_q;
    ctrl_d   = ctrl_q;
    if (MemWrite && hit) begin
      case (Addr[3:2])
        OFF_DISP: disp_d   = (disp_q & ~wmask) | (wdata & wmask);
        OFF_LED:  ledreg_d = ((ledreg_q & ~wmask) | (wdata & wmask)) & LED_WMASK;
        OFF_CTRL: ctrl_d   = ((ctrl_q & ~wmask) | (wdata & wmask)) & CTRL_WMASK;
        default:  ;
      endcase
    end
  end

  // Load path sees pre-write register values.
  always_comb begin
    case (Addr[3:2])
      OFF_DISP: rword = disp_q;
      OFF_LED:  rword = ledreg_q;
      OFF_CTRL: rword = ctrl_q;
      default:  rword = {frame_q, 13'b0, idx_q};
    endcase
    rshift   = rword >> {Addr[1:0], 3'b000};
    ReadData = 32'h0;
    if (MemRead && hit) begin
      case (funct3)
        F3_B:  ReadData = {{24{rshift[7]}}, rshift[7:0]};
        F3_BU: ReadData = {24'h0, rshift[7:0]};
        F3_H:  if (!Addr[0]) ReadData = {{16{rshift[15]}}, rshift[15:0]};
        F3_HU: if (!Addr[0]) ReadData = {16'h0, rshift[15:0]};
        F3_W:  if (Addr[1:0] == 2'b00) ReadData = rword;
        default: ReadData = 32'h0;
      endcase
    end
  end

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    frame_d = (tick && idx_q == 3'd7) ? frame_q + 16'd1 : frame_q;
  end

  assign nib        = disp_q[{idx_q, 2'b00} +: 4];
  assign dp_mask    = ctrl_q[CTRL_DP_LSB +: 8];
  assign blank_mask = ctrl_q[CTRL_BLANK_LSB +: 8];

  hex_to_seg7 u_hex (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  always_comb begin
    digit_on = ctrl_q[CTRL_EN_BIT] && !blank_mask[idx_q];
    an_d     = 8'hFF;
    seg_d    = 8'hFF;
    if (digit_on) begin
      an_d  = ~(8'b0000_0001 << idx_q);
      seg_d = ~{dp_mask[idx_q], hex_seg};
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      disp_q   <= 32'h0;
      ledreg_q <= 32'h0;
      ctrl_q   <= CTRL_RST;
      presc_q  <= '0;
      idx_q    <= 3'd0;
      frame_q  <= 16'd0;
      seg_q    <= 8'hFF;
      an_q     <= 8'hFF;
      led_q    <= 16'h0;
    end else begin
      disp_q   <= disp_d;
      ledreg_q <= ledreg_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      led_q    <= ledreg_q[15:0];
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign led = led_q;

endmodule

// File: tb/tb_mmio_seg7_port.sv
// Directed plus randomized bench for mmio_seg7_port against a byte-level
// register/scanner reference model.
module tb_mmio_seg7_port;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam int SD = 4;

  logic        CLK = 1'b0;
  logic        Reset, MemWrite, MemRead;
  logic [2:0]  funct3;
  logic [31:0] Addr, WriteData, ReadData;
  logic        hit;
  logic [7:0]  seg, an;
  logic [15:0] led;

  always #5 CLK = ~CLK;

  mmio_seg7_port #(.BASE_ADDR(BASE), .SCAN_DIV(SD)) dut (
    .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .funct3(funct3), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .hit(hit), .seg(seg), .an(an), .led(led)
  );

  logic [31:0] m_disp, m_led, m_ctrl;
  int          m_presc, m_idx, m_frame;
  logic [7:0]  e_seg, e_an;
  logic [15:0] e_led;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic m_reset();
    m_disp = 0; m_led = 0; m_ctrl = 32'h1;
    m_presc = 0; m_idx = 0; m_frame = 0;
    e_seg = 8'hFF; e_an = 8'hFF; e_led = 0;
  endtask

  function automatic logic [31:0] m_word(input int off);
    case (off)
      0: return m_disp;
      1: return m_led;
      2: return m_ctrl;
      default: return {16'(m_frame), 13'b0, 3'(m_idx)};
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic re, input logic [2:0] f3, input logic [31:0] a);
    int lane;
    logic [31:0] w;
    if (!re || a[31:4] != BASE[31:4]) return 0;
    lane = int'(a[1:0]);
    w = m_word(int'(a[3:2])) >> (8 * lane);
    case (f3)
      3'd0: return {{24{w[7]}}, w[7:0]};
      3'd4: return {24'h0, w[7:0]};
      3'd1: return (lane % 2 != 0) ? 0 : {{16{w[15]}}, w[15:0]};
      3'd5: return (lane % 2 != 0) ? 0 : {16'h0, w[15:0]};
      3'd2: return (lane != 0) ? 0 : w;
      default: return 0;
    endcase
  endfunction

  task automatic m_write(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int lane, n, base;
    logic [31:0] r;
    lane = int'(a[1:0]);
    case (f3)
      3'd0: begin n = 1; base = lane; end
      3'd1: begin if (lane % 2 != 0) return; n = 2; base = lane; end
      3'd2: begin if (lane != 0) return; n = 4; base = 0; end
      default: return;
    endcase
    r = m_word(int'(a[3:2]));
    for (int b = 0; b < n; b++) r[8*(base+b) +: 8] = wd[8*b +: 8];
    case (int'(a[3:2]))
      0: m_disp = r;
      1: m_led  = r & 32'h0000_FFFF;
      2: m_ctrl = r & 32'h00FF_FF01;
      default: ;
    endcase
  endtask

  // One bus cycle: check combinational outputs, advance the model at the edge,
  // then check the registered outputs.
  task automatic op(input logic we, input logic re, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd, output logic [31:0] r);
    bit on;
    MemWrite = we; MemRead = re; funct3 = f3; Addr = a; WriteData = wd;
    #1;
    r = ReadData;
    check("hit", {31'b0, hit}, {31'b0, a[31:4] == BASE[31:4]});
    check("rdata", ReadData, m_read(re, f3, a));
    @(posedge CLK);
    on = m_ctrl[0] && !m_ctrl[16 + m_idx];
    e_an  = on ? ~(8'd1 << m_idx) : 8'hFF;
    e_seg = on ? ~{m_ctrl[8 + m_idx], hex7(int'(m_disp[4*m_idx +: 4]))} : 8'hFF;
    e_led = m_led[15:0];
    if (we && a[31:4] == BASE[31:4]) m_write(f3, a, wd);
    if (m_presc == SD - 1) begin
      m_presc = 0;
      m_idx = (m_idx + 1) % 8;
      if (m_idx == 0) m_frame = (m_frame + 1) % 65536;
    end else m_presc++;
    #1;
    check("seg", {24'b0, seg}, {24'b0, e_seg});
    check("an", {24'b0, an}, {24'b0, e_an});
    check("led", {16'b0, led}, {16'b0, e_led});
  endtask

  task automatic idle(input int n);
    logic [31:0] tmp;
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 3'd0, BASE, 32'h0, tmp);
  endtask

  initial begin
    Reset = 1'b1; MemWrite = 0; MemRead = 0; funct3 = 0; Addr = 0; WriteData = 0;
    m_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_seg", {24'b0, seg}, 32'hFF);
    check("rst_an", {24'b0, an}, 32'hFF);
    check("rst_led", {16'b0, led}, 32'h0);
    Reset = 1'b0;

    op(1, 0, 3'd2, BASE, 32'h1234_ABCD, rd);
    op(0, 1, 3'd2, BASE, 32'h0, rd);
    check("lw_disp", rd, 32'h1234_ABCD);
    check("digit0_an", {24'b0, an}, 32'hFE);
    check("digit0_seg", {24'b0, seg}, 32'hA1);

    op(1, 0, 3'd0, BASE + 5, 32'h0000_0080, rd);
    op(0, 1, 3'd0, BASE + 5, 32'h0, rd);
    check("lb_led", rd, 32'hFFFF_FF80);
    check("led_out", {16'b0, led}, 32'h8000);
    op(0, 1, 3'd4, BASE + 5, 32'h0, rd);
    check("lbu_led", rd, 32'h0000_0080);

    op(1, 0, 3'd1, BASE + 1, 32'h0000_FFFF, rd);
    op(0, 1, 3'd2, BASE, 32'h0, rd);
    check("sh_misaligned", rd, 32'h1234_ABCD);
    op(0, 1, 3'd1, BASE + 1, 32'h0, rd);
    check("lh_misaligned", rd, 32'h0);

    idle(32);
    op(0, 1, 3'd2, BASE + 12, 32'h0, rd);

    op(1, 0, 3'd2, BASE + 8, 32'h00FF_0001, rd);
    idle(1);
    check("blank_an", {24'b0, an}, 32'hFF);
    check("blank_seg", {24'b0, seg}, 32'hFF);
    op(1, 0, 3'd2, BASE + 8, 32'h0, rd);
    idle(12);
    op(0, 1, 3'd2, BASE + 12, 32'h0, rd);
    idle(5);
    op(0, 1, 3'd2, BASE + 12, 32'h0, rd);
    op(1, 0, 3'd2, BASE + 8, 32'h0000_FF01, rd);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = BASE + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      op(1'($urandom), 1'($urandom), 3'($urandom), a, $urandom, rd);
    end

    op(1, 0, 3'd2, BASE, 32'h8765_4321, rd);
    op(1, 0, 3'd2, BASE + 8, 32'h0000_0001, rd);
    idle(6);
    #2 Reset = 1'b1;
    #1;
    check("midscan_seg", {24'b0, seg}, 32'hFF);
    check("midscan_an", {24'b0, an}, 32'hFF);
    check("midscan_led", {16'b0, led}, 32'h0);
    m_reset();
    MemWrite = 1; MemRead = 0; funct3 = 3'd2; Addr = BASE + 4; WriteData = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1 Reset = 1'b0;
    op(0, 1, 3'd2, BASE, 32'h0, rd);
    check("post_rst_disp", rd, 32'h0);
    op(0, 1, 3'd2, BASE + 8, 32'h0, rd);
    check("post_rst_ctrl", rd, 32'h1);
    op(0, 1, 3'd2, BASE + 4, 32'h0, rd);
    check("store_lost", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_seg7_port.md
Name: mmio_seg7_port

Overview:
- Memory-mapped output-port responder on the CPU data-memory bus, sitting beside the data memory and decoded from the same MEM-stage address.
- The CPU reads switches through the data memory. This block is the opposite direction: stores from the CPU drive the 8-digit seven-segment display and the 16 LEDs.
- Provides load-readback of its registers and an internal time-multiplexed digit scanner.

Parameters:
- BASE_ADDR, 32'h0000_FF00, register window base; must be 16-byte aligned.
- SCAN_DIV, 100000, clock cycles per digit slot (2..2^20).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  store strobe, MEM stage.
- MemRead  in  1  load strobe, MEM stage.
- funct3  in  3  access size/sign, RISC-V encoding.
- Addr  in  32  byte address.
- WriteData  in  32  store data, right-aligned.
- ReadData  out  32  load data, combinational, already extended.
- hit  out  1  Addr[31:4]==BASE_ADDR[31:4]; the top level uses it to select this block over the data memory.
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- an  out  8  active-low digit enables.
- led  out  16  LED drive.

Behaviour:
- Register map (offset = Addr[3:2]):
  - 0 DISP: 32 bits, digit k = DISP[4k+3:4k].
  - 1 LED: bits [15:0], upper bits read 0.
  - 2 CTRL: [0] enable, [15:8] dp mask, [23:16] blank mask.
  - 3 STATUS: read-only, [2:0] current digit, [31:16] frame count.
- Reset (async, immediate):
  - DISP=0, LED=0, CTRL=32'h0000_0001.
  - Prescaler, digit index and frame count = 0.
  - seg=8'hFF, an=8'hFF, led=0.
- Writes take effect on the rising CLK edge when MemWrite && hit.
  - sb (000): byte lane Addr[1:0] gets WriteData[7:0].
  - sh (001): half lane Addr[1] gets WriteData[15:0]. Ignored if Addr[0]=1.
  - sw (010): whole word. Ignored if Addr[1:0]!=0.
  - Other funct3 codes: ignored.
  - Writes to STATUS and to LED[31:16]/CTRL reserved bits: ignored.
- Reads are combinational when MemRead && hit; otherwise ReadData=0.
  - Selected word is shifted by the same lane rules as writes.
  - lb: sign-extend 8 bits. lh: sign-extend 16 bits. lw: full word. lbu: zero-extend 8 bits. lhu: zero-extend 16 bits.
  - Misaligned or other funct3: ReadData=0.
- A read and a write in the same cycle to the same register: ReadData shows the pre-write value.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1. A tick is asserted in the cycle where the count equals SCAN_DIV-1, then the count wraps to 0.
  - On tick, digit index increments mod 8.
  - On the 7->0 wrap, frame count increments mod 2^16.
- seg/an are registered and reflect the index/registers of the previous cycle (1-cycle latency).
  - an = ~(8'b1<<idx) when CTRL[0]=1 and CTRL[16+idx]=0; otherwise 8'hFF.
  - seg = ~{CTRL[8+idx], hex7(DISP nibble idx)}.
  - When an is all-ones, seg = 8'hFF.
- hex7 decodes 0-F to standard a..g patterns (active-high internally, inverted at the output).
- led is registered from LED[15:0]; it updates the cycle after the write edge.
- Clearing CTRL enable does not stop the scanner; it only blanks the outputs.
- A write and a tick in the same cycle: both apply. The new register values appear on seg on the next output update.
- Reset asserted mid-scan or mid-store: all state returns to reset values immediately, and the store is lost.

Decomposition:
- Shared package holds:
  - Offset constants OFF_DISP/OFF_LED/OFF_CTRL/OFF_STATUS.
  - funct3 codes F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - CTRL bit positions.
- One natural sub-module: hex_to_seg7 (4-bit nibble in, 7-bit active-high segments out, combinational).

Test Plan:
- Reset, then sw 32'h1234_ABCD to BASE+0 and lw BASE+0 -> ReadData=32'h1234_ABCD. With SCAN_DIV=4, digit 0 shows an=8'hFE, seg=~{0,7'h5E} ("d").
- sb 8'h80 to BASE+5, then lb BASE+5 and lbu BASE+5 -> 32'hFFFF_FF80 and 32'h0000_0080; led=16'h8000.
- sh to BASE+1 (misaligned) with 16'hFFFF -> DISP unchanged; lh BASE+1 -> 0.
- SCAN_DIV=4, run 32 cycles -> an sequence FE,FD,...,7F, each held 4 cycles. STATUS[31:16] increments by 1 at the 7->0 wrap.
- sw 32'h00FF_0001 to BASE+8 (blank all digits) -> an=8'hFF, seg=8'hFF within 1 cycle. Write CTRL=0 -> outputs stay 8'hFF while STATUS[2:0] keeps advancing.
- Assert Reset mid-scan with DISP nonzero -> seg/an=8'hFF and led=0 immediately; lw BASE+0 -> 0; lw BASE+8 -> 1.
